pulse_width_decoder: RTL and testbench
======================================

Name: pulse_width_decoder

Overview:
- Receive-side counterpart of the single-shot timer: measures the high time of an incoming single-shot pulse and decodes it back to the 2-bit mode code that produced it.
- Sits on the far end of the pulse wire, e.g. in a loop-back checker or a downstream consumer.
- Delivers each decoded result over a valid/ready handshake, with error classification for off-nominal and stuck pulses.

Parameters:
- WIDTH, 9, timer width; the measurement counter is WIDTH+1 bits.
- TOL, 2, allowed deviation in cycles (±) from a nominal width.
- MAX_CYC, 512, high-time limit; reaching it is a timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pulse_in  in  1  pulse to measure, synchronous to clk
- busy  out  1  high while in MEASURE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_mode  out  2  decoded mode code
- res_err  out  2  00 OK, 01 NOMATCH, 10 TIMEOUT
- res_width  out  WIDTH+1  measured high cycles
- overrun  out  1  one-cycle strobe: completed measurement dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - State goes to ARM.
  - busy, res_valid and overrun go to 0; res_mode, res_err and res_width go to 0.
  - Reset mid-pulse discards the partial measurement.
- Nominal widths: NOM_k = (32<<k)+1 cycles, k=0..3, i.e. 33, 65, 129, 257. This matches the timer, whose pulse stays high for duration+1 cycles.
- FSM states:
  - ARM:
    - Waits for pulse_in=0, then goes to IDLE.
    - Prevents measuring a pulse already high at reset release or after a timeout.
  - IDLE:
    - If pulse_in=1, go to MEASURE with count=1.
  - MEASURE:
    - If pulse_in=1 and count+1 < MAX_CYC: count++.
    - If pulse_in=1 and count+1 == MAX_CYC: complete with TIMEOUT, res_width=MAX_CYC, go to ARM.
    - If pulse_in=0: complete, classify count, go to IDLE.
    - A new rising edge can be taken on the cycle after return to IDLE.
- Classification:
  - If |count − NOM_k| <= TOL for some k, report res_mode=k and res_err=OK.
  - Otherwise report res_mode=0 and res_err=NOMATCH.
  - Tolerance windows cannot overlap at TOL<16.
  - The comparison uses WIDTH+2-bit signed arithmetic; there is no wrap.
- Latency: res_valid rises on the clock edge after the first low sample of pulse_in (or after the timeout cycle).
- Handshake:
  - res_valid and all res_* fields are held stable until res_valid && res_ready.
  - res_valid drops the cycle after acceptance unless a new completion loads in the same cycle.
  - A completion in the same cycle as acceptance loads the new result with no gap.
- Overrun:
  - A completion while res_valid=1 and res_ready=0 drops the new result.
  - overrun pulses high for 1 cycle; the held result is unchanged.
- Measurement is never stalled by backpressure; pulse_in is always sampled.

Optional Feature:
- PULSE_SYNC_EN defined:
  - pulse_in passes through a 2-flop synchronizer, reset to 0, before the FSM.
  - Allows an asynchronous source.
  - Adds 2 cycles to every latency.
  - Measured widths are unchanged for clean pulses.
- Undefined:
  - pulse_in is used directly; zero added latency.

Decomposition:
- Shared package holds:
  - the decoder state enum (ARM, IDLE, MEASURE);
  - the res_err encoding enum (OK, NOMATCH, TIMEOUT);
  - the nominal-width constants NOM_k, which the timer's mode table also uses, so both ends share one definition.
- Sub-module pulse_sync (2-flop synchronizer), instantiated only under PULSE_SYNC_EN.

Test Plan:
- pulse_in high 33 cycles, res_ready=1 -> res_valid 1 cycle after the falling sample; res_mode=0, res_err=OK, res_width=33. Repeat for 65/129/257 -> modes 1/2/3. Repeat for 31 and 259 -> still OK within TOL=2.
- pulse_in high 48 cycles -> res_err=NOMATCH, res_mode=0, res_width=48. Also 36 cycles -> NOMATCH.
- pulse_in held high 600 cycles -> res_err=TIMEOUT, res_width=512 at cycle 512. No further result until pulse_in falls and a new rising edge arrives.
- res_ready=0; send pulses of 65 then 129 cycles -> first result held (mode 1); overrun strobes once at the second pulse's end. Raise res_ready -> one handshake, then res_valid=0.
- Assert rst_n low mid-pulse (count 40) with pulse_in staying high -> all outputs 0 and state ARM. No result for the remainder of that pulse; the next full 33-cycle pulse decodes mode 0.
- Loop-back: single_shot_timer pulse_out drives pulse_in and fire_valid cycles modes 0..3 -> decoded res_mode equals the fired mode each time, and res_err=OK.

Source files
------------

// File: rtl/pulse_width_decoder_pkg.sv
// Purpose : shared decoder types and the nominal pulse widths common to timer and decoder.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pulse_width_decoder_pkg;

   typedef enum logic [1:0] {
      ST_ARM     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_MEASURE = 2'd2
   } dec_state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NOMATCH = 2'b01,
      ERR_TIMEOUT = 2'b10
   } res_err_t;

   // The timer holds its pulse high for duration+1 cycles, duration = 32<<mode.
   localparam int unsigned NOM_0 = (32 << 0) + 1;
   localparam int unsigned NOM_1 = (32 << 1) + 1;
   localparam int unsigned NOM_2 = (32 << 2) + 1;
   localparam int unsigned NOM_3 = (32 << 3) + 1;

   function automatic int unsigned nom_width(input int k);
      case (k)
         0:       return NOM_0;
         1:       return NOM_1;
         2:       return NOM_2;
         default: return NOM_3;
      endcase
   endfunction

endpackage

// File: rtl/pulse_width_decoder_pulse_sync.sv
// Purpose : 2-flop synchronizer for an asynchronous pulse source, flops reset to 0.
// Latency : 2 clk cycles.
// Backpressure: none; samples every cycle.
// Ports   : clk, rst_n (async active-low), din (async in), dout (synchronized out).
module pulse_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/pulse_width_decoder.sv
// Purpose : measures pulse high time and decodes it to the timer mode code, with error class.
// Latency : result valid on the edge after the first low sample (or the timeout cycle);
//           +2 cycles when PULSE_SYNC_EN is defined (2-flop input synchronizer).
// Backpressure: measurement never stalls; a completion while a result is held unaccepted
//           is dropped and flagged by a one-cycle overrun strobe.
// Ports   : clk, rst_n, pulse_in | busy | res_valid/res_ready, res_mode, res_err, res_width | overrun
module pulse_width_decoder
   import pulse_width_decoder_pkg::*;
#(
   parameter int WIDTH   = 9,
   parameter int TOL     = 2,
   parameter int MAX_CYC = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_mode,
   output logic [1:0]       res_err,
   output logic [WIDTH:0]   res_width,
   output logic             overrun
);

   localparam int CW = WIDTH + 1;
   localparam logic [CW-1:0]        MAX_C = CW'(MAX_CYC);
   localparam logic signed [CW:0]   TOL_S = (CW+1)'(TOL);

   logic pulse;

`ifdef PULSE_SYNC_EN
   pulse_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (pulse_in),
      .dout (pulse)
   );
`else
   assign pulse = pulse_in;
`endif

   dec_state_t     state;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_inc;

   assign count_inc = count + CW'(1);

   // Classification: one extra bit so count - NOM never wraps.
   logic [1:0]          cls_mode;
   res_err_t            cls_err;
   logic signed [CW:0]  diff;

   always_comb begin
      cls_mode = 2'd0;
      cls_err  = ERR_NOMATCH;
      diff     = '0;
      for (int k = 0; k < 4; k++) begin
         diff = $signed({1'b0, count}) - $signed((CW+1)'(nom_width(k)));
         if (diff >= -TOL_S && diff <= TOL_S) begin
            cls_mode = 2'(k);
            cls_err  = ERR_OK;
         end
      end
   end

   // Completion of a measurement this cycle, and the result it produces.
   logic           done;
   logic [1:0]     done_mode;
   res_err_t       done_err;
   logic [CW-1:0]  done_width;

   always_comb begin
      done       = 1'b0;
      done_mode  = 2'd0;
      done_err   = ERR_OK;
      done_width = count;
      if (state == ST_MEASURE) begin
         if (pulse && count_inc == MAX_C) begin
            done       = 1'b1;
            done_err   = ERR_TIMEOUT;
            done_width = MAX_C;
         end else if (!pulse) begin
            done      = 1'b1;
            done_mode = cls_mode;
            done_err  = cls_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ARM;
         busy      <= 1'b0;
         count     <= '0;
         res_valid <= 1'b0;
         res_mode  <= 2'd0;
         res_err   <= 2'd0;
         res_width <= '0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            // ARM blocks a pulse already high at reset release or after timeout.
            ST_ARM: begin
               if (!pulse) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (pulse) begin
                  state <= ST_MEASURE;
                  busy  <= 1'b1;
                  count <= CW'(1);
               end
            end
            ST_MEASURE: begin
               if (pulse) begin
                  if (count_inc == MAX_C) begin
                     state <= ST_ARM;
                     busy  <= 1'b0;
                  end else begin
                     count <= count_inc;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_ARM;
               busy  <= 1'b0;
            end
         endcase

         overrun <= done && res_valid && !res_ready;

         // Load on completion when the output slot is free or being accepted now.
         if (done && (!res_valid || res_ready)) begin
            res_valid <= 1'b1;
            res_mode  <= done_mode;
            res_err   <= done_err;
            res_width <= done_width;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_width_decoder.sv
module tb_pulse_width_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pulse_in;
   logic       busy;
   logic       res_valid;
   logic       res_ready;
   logic [1:0] res_mode;
   logic [1:0] res_err;
   logic [9:0] res_width;
   logic       overrun;

   pulse_width_decoder #(.WIDTH(9), .TOL(2), .MAX_CYC(512)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (pulse_in),
      .busy     (busy),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_mode (res_mode),
      .res_err  (res_err),
      .res_width(res_width),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ov_cnt   = 0;
   int vld_cnt  = 0;

   typedef struct {
      int hi;
      int mode;
      int err;
      int width;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance one cycle; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (overrun)   ov_cnt++;
      if (res_valid) vld_cnt++;
   endtask

   // Leaves the caller just after the edge that sampled the last high cycle, pulse_in now low.
   task automatic drive_pulse(input int hi);
      tick();
      pulse_in = 1'b1;
      repeat (hi) tick();
      pulse_in = 1'b0;
   endtask

   // Reference: classify a high time directly from nominal widths (32<<k)+1 and tolerance 2.
   function automatic void model(input int n, output int m, output int e, output int w);
      m = 0;
      if (n >= 512) begin
         e = 2;
         w = 512;
         return;
      end
      e = 1;
      w = n;
      for (int k = 0; k < 4; k++) begin
         int d;
         d = n - ((32 << k) + 1);
         if (d < 0) d = -d;
         if (d <= 2) begin
            m = k;
            e = 0;
         end
      end
   endfunction

   // Full pulse with res_ready=1: checks latency, fields and drop after acceptance.
   task automatic apply_pulse(input int hi, input int m, input int e, input int w, input string tag);
      drive_pulse(hi);
      check({tag, "_early_valid"}, int'(res_valid), 0);
      check({tag, "_busy_meas"},   int'(busy), 1);
      tick();
      check({tag, "_valid"}, int'(res_valid), 1);
      check({tag, "_mode"},  int'(res_mode), m);
      check({tag, "_err"},   int'(res_err), e);
      check({tag, "_width"}, int'(res_width), w);
      check({tag, "_busy_done"}, int'(busy), 0);
      tick();
      check({tag, "_valid_drop"}, int'(res_valid), 0);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int first, gm, ge, gw, m, e, w, hi, kind, k;

      tbl[0]  = '{33,  0, 0, 33};
      tbl[1]  = '{65,  1, 0, 65};
      tbl[2]  = '{129, 2, 0, 129};
      tbl[3]  = '{257, 3, 0, 257};
      tbl[4]  = '{31,  0, 0, 31};
      tbl[5]  = '{259, 3, 0, 259};
      tbl[6]  = '{48,  0, 1, 48};
      tbl[7]  = '{36,  0, 1, 36};
      tbl[8]  = '{35,  0, 0, 35};
      tbl[9]  = '{62,  0, 1, 62};
      tbl[10] = '{127, 2, 0, 127};
      tbl[11] = '{1,   0, 1, 1};
      tbl[12] = '{511, 0, 1, 511};

      rst_n     = 1'b0;
      pulse_in  = 1'b0;
      res_ready = 1'b1;
      #12;
      check("rst_busy",    int'(busy), 0);
      check("rst_valid",   int'(res_valid), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_mode",    int'(res_mode), 0);
      check("rst_err",     int'(res_err), 0);
      check("rst_width",   int'(res_width), 0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Table-driven decode vectors.
      foreach (tbl[i]) begin
         apply_pulse(tbl[i].hi, tbl[i].mode, tbl[i].err, tbl[i].width, $sformatf("tbl%0d", i));
      end

      // Stuck-high pulse: timeout at the 512th high sample, nothing more until a new edge.
      vld_cnt = 0;
      first   = 0;
      gm = 0; ge = 0; gw = 0;
      tick();
      pulse_in = 1'b1;
      for (int i = 1; i <= 600; i++) begin
         tick();
         if (res_valid && first == 0) begin
            first = i;
            gm = int'(res_mode);
            ge = int'(res_err);
            gw = int'(res_width);
         end
      end
      check("to_cycle", first, 512);
      check("to_err",   ge, 2);
      check("to_width", gw, 512);
      check("to_mode",  gm, 0);
      check("to_busy_armed", int'(busy), 0);
      pulse_in = 1'b0;
      repeat (5) tick();
      check("to_single_result", vld_cnt, 1);
      apply_pulse(33, 0, 0, 33, "after_to");

      // Backpressure: first result held, second dropped with one overrun strobe.
      res_ready = 1'b0;
      ov_cnt    = 0;
      drive_pulse(65);
      tick();
      check("bp_valid1", int'(res_valid), 1);
      check("bp_mode1",  int'(res_mode), 1);
      repeat (3) tick();
      drive_pulse(129);
      tick();
      check("bp_ov_strobe", ov_cnt, 1);
      repeat (3) tick();
      check("bp_ov_once", ov_cnt, 1);
      check("bp_held_valid", int'(res_valid), 1);
      check("bp_held_mode",  int'(res_mode), 1);
      check("bp_held_width", int'(res_width), 65);
      res_ready = 1'b1;
      tick();
      check("bp_drop_after_accept", int'(res_valid), 0);

      // Acceptance and completion on the same edge: new result loads with no gap.
      res_ready = 1'b0;
      drive_pulse(33);
      tick();
      check("same_valid1", int'(res_valid), 1);
      repeat (2) tick();
      ov_cnt = 0;
      drive_pulse(129);
      res_ready = 1'b1;
      tick();
      check("same_valid2", int'(res_valid), 1);
      check("same_mode2",  int'(res_mode), 2);
      check("same_width2", int'(res_width), 129);
      check("same_no_ov",  ov_cnt, 0);
      tick();
      check("same_drop", int'(res_valid), 0);
      repeat (2) tick();

      // Reset mid-pulse at count 40, pulse stays high: no result for the rest of it.
      tick();
      pulse_in = 1'b1;
      repeat (40) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  int'(busy), 0);
      check("mid_rst_valid", int'(res_valid), 0);
      check("mid_rst_width", int'(res_width), 0);
      tick();
      rst_n   = 1'b1;
      vld_cnt = 0;
      repeat (30) tick();
      check("mid_rst_armed_busy", int'(busy), 0);
      pulse_in = 1'b0;
      repeat (4) tick();
      check("mid_rst_no_result", vld_cnt, 0);
      apply_pulse(33, 0, 0, 33, "after_rst");

      // Randomized: timer-style nominal pulses, jittered pulses and arbitrary widths.
      for (int i = 0; i < 50; i++) begin
         kind = int'($urandom_range(0, 2));
         k    = int'($urandom_range(0, 3));
         if (kind == 0)      hi = (32 << k) + 1;
         else if (kind == 1) hi = (32 << k) + 1 + int'($urandom_range(0, 6)) - 3;
         else                hi = int'($urandom_range(1, 511));
         model(hi, m, e, w);
         apply_pulse(hi, m, e, w, $sformatf("rnd%0d_hi%0d", i, hi));
         if (kind == 0) check($sformatf("loop%0d_mode", i), int'(res_mode) == k ? m : -1, k);
         repeat (int'($urandom_range(0, 4))) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
